// File: rtl/sm83_pkg.sv
// Shared SM83 fetch types and sizing; SM83_FETCH_PREFETCH_EN selects a 2-byte prefetch buffer.
// Purely declarative: no latency, no backpressure.
package sm83_pkg;

    typedef logic [7:0] instr_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DISCARD
    } fetch_state_t;

    localparam instr_t OP_INSTR_16 = 8'hCB;

`ifdef SM83_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(DEPTH + 1);

endpackage

// File: rtl/sm83_fetch_buf.sv
// Byte/PC FIFO with flush; head is visible directly from registers.
// Push lands one cycle later; caller must not push when full, pops on empty are ignored.
module sm83_fetch_buf
    import sm83_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  instr_t        push_byte,
    input  logic [15:0]   push_pc,
    input  logic          pop,
    output instr_t        head_byte,
    output logic [15:0]   head_pc,
    output logic [CW-1:0] count
);

    instr_t        byte_q [DEPTH];
    logic [15:0]   pc_q   [DEPTH];
    logic [CW-1:0] count_q;
    logic          do_pop;
    int            wr_idx;

    assign do_pop    = pop && (count_q != '0);
    assign head_byte = byte_q[0];
    assign head_pc   = pc_q[0];
    assign count     = count_q;

    // Entry 0 is always the head, so a pop shifts everything down one slot.
    always_comb begin
        wr_idx = int'(count_q) - int'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                byte_q[i] <= 8'h00;
                pc_q[i]   <= RESET_PC;
            end
        end else if (flush) begin
            count_q <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    byte_q[i] <= byte_q[i + 1];
                    pc_q[i]   <= pc_q[i + 1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == wr_idx) begin
                        byte_q[i] <= push_byte;
                        pc_q[i]   <= push_pc;
                    end
                end
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sm83_fetch.sv
// SM83 instruction byte fetcher (SM83_FETCH_PREFETCH_EN enables fetch-ahead); bytes appear one cycle after mem_rvalid.
// Requests stall while the buffer plus the single outstanding read would overflow, on i_halt, or on i_pc_load.
module sm83_fetch
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  instr_t      mem_rdata,
    output logic        o_valid,
    output instr_t      o_byte,
    output logic [15:0] o_pc,
    output logic        o_is_instr16,
    input  logic        i_pop,
    input  logic        i_pop_operand,
    input  logic        i_pc_load,
    input  logic [15:0] i_pc_target,
    input  logic        i_halt
);

    fetch_state_t     state;
    logic [15:0]      fetch_pc;
    logic [15:0]      req_pc;
    logic             started;
    logic             cb_pending;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // started keeps mem_req low while reset is held and for the first cycle after release.
    assign mem_req      = started && (state == RUN) && !i_halt && !i_pc_load
                          && (int'(count) < DEPTH);
    assign mem_addr     = fetch_pc;
    assign push         = (state == WAIT) && mem_rvalid && !i_pc_load;
    assign pop          = i_pop && o_valid && !i_pc_load;
    assign o_valid      = (count != '0);
    assign o_is_instr16 = cb_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            started    <= 1'b0;
            cb_pending <= 1'b0;
        end else begin
            started <= 1'b1;

            if (i_pc_load) begin
                fetch_pc   <= i_pc_target;
                cb_pending <= 1'b0;
            end else if (pop && !i_pop_operand) begin
                cb_pending <= (o_byte == OP_INSTR_16);
            end

            case (state)
                RUN: begin
                    if (mem_req && mem_gnt) begin
                        state    <= WAIT;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 16'd1;
                    end
                end
                // A redirect while the read is in flight turns its response into one to drop.
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= RUN;
                    end else if (i_pc_load) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_rvalid) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sm83_fetch_buf #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (i_pc_load),
        .push      (push),
        .push_byte (mem_rdata),
        .push_pc   (req_pc),
        .pop       (pop),
        .head_byte (o_byte),
        .head_pc   (o_pc),
        .count     (count)
    );

endmodule

// File: tb/tb_sm83_fetch.sv
// Self-checking bench for sm83_fetch: queue-based reference model plus directed literal scenarios.
module tb_sm83_fetch;
    import sm83_pkg::*;

    localparam int P_NONE  = 0;
    localparam int P_LIVE  = 1;
    localparam int P_STALE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    instr_t      mem_rdata;
    logic        o_valid;
    instr_t      o_byte;
    logic [15:0] o_pc;
    logic        o_is_instr16;
    logic        i_pop;
    logic        i_pop_operand;
    logic        i_pc_load;
    logic [15:0] i_pc_target;
    logic        i_halt;

    always #5 clk = ~clk;

    sm83_fetch #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .o_valid       (o_valid),
        .o_byte        (o_byte),
        .o_pc          (o_pc),
        .o_is_instr16  (o_is_instr16),
        .i_pop         (i_pop),
        .i_pop_operand (i_pop_operand),
        .i_pc_load     (i_pc_load),
        .i_pc_target   (i_pc_target),
        .i_halt        (i_halt)
    );

    typedef struct {
        logic [7:0]  b;
        logic [15:0] pc;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem_img [0:65535];

    ent_t        mq[$];
    bit          m_cb;
    logic [15:0] m_fpc;
    logic [15:0] m_live;
    int          m_pend;

    bit          r_pend;
    logic [15:0] r_addr;
    int          r_cnt;
    int          gnt_pct;
    int          dmin;
    int          dmax;
    int          stray_pct;
    bit          force_stray;

    logic [7:0]  pop_b[$];
    logic [15:0] pop_pc[$];
    bit          pop_16[$];
    logic [15:0] gnt_log[$];
    int          req_cycles;
    logic [15:0] rnd_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        pop_b.delete();
        pop_pc.delete();
        pop_16.delete();
        gnt_log.delete();
    endtask

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic cyc(input bit p_pop, input bit p_opnd, input bit p_load,
                       input logic [15:0] p_tgt, input bit p_halt);
        bit exp_req;
        bit hs;
        bit popeff;
        i_pop         = p_pop;
        i_pop_operand = p_opnd;
        i_pc_load     = p_load;
        i_pc_target   = p_tgt;
        i_halt        = p_halt;
        mem_gnt       = ($urandom_range(99) < gnt_pct);
        if (r_pend) begin
            mem_rvalid = (r_cnt == 0);
            mem_rdata  = mem_img[r_addr];
        end else begin
            mem_rvalid = force_stray || ($urandom_range(99) < stray_pct);
            mem_rdata  = 8'($urandom);
        end
        #4;
        exp_req = (m_pend == P_NONE) && !p_halt && !p_load && (mq.size() < DEPTH);
        chk("o_valid", 32'(o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("o_byte", 32'(o_byte), 32'(mq[0].b));
            chk("o_pc", 32'(o_pc), 32'(mq[0].pc));
        end
        chk("o_is_instr16", 32'(o_is_instr16), 32'(m_cb));
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(m_fpc));
        if (mem_req) req_cycles++;
        if (p_pop && o_valid && !p_load) begin
            pop_b.push_back(o_byte);
            pop_pc.push_back(o_pc);
            pop_16.push_back(o_is_instr16);
        end

        hs     = exp_req && mem_gnt;
        popeff = p_pop && (mq.size() != 0) && !p_load;
        if (p_load) begin
            mq.delete();
            m_cb  = 1'b0;
            m_fpc = p_tgt;
            if (m_pend != P_NONE) m_pend = mem_rvalid ? P_NONE : P_STALE;
        end else begin
            if (popeff) begin
                if (!p_opnd) m_cb = (mq[0].b == 8'hCB);
                void'(mq.pop_front());
            end
            if (mem_rvalid && m_pend == P_LIVE) mq.push_back('{mem_img[m_live], m_live});
            if (mem_rvalid) m_pend = P_NONE;
            if (hs) begin
                m_pend = P_LIVE;
                m_live = m_fpc;
                m_fpc  = m_fpc + 16'd1;
            end
        end

        if (mem_rvalid && r_pend && r_cnt == 0) r_pend = 1'b0;
        else if (r_pend) r_cnt--;
        if (mem_req && mem_gnt) begin
            r_pend = 1'b1;
            r_addr = mem_addr;
            r_cnt  = int'($urandom_range(dmax, dmin));
            gnt_log.push_back(mem_addr);
        end
        force_stray = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        i_halt     = 1'b1;
        i_pop      = 1'b0;
        i_pc_load  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #2;
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_o_is_instr16", 32'(o_is_instr16), 32'h0);
        chk("rst_o_pc", 32'(o_pc), 32'h0000);
        chk("rst_o_byte", 32'(o_byte), 32'h00);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        mq.delete();
        m_cb   = 1'b0;
        m_fpc  = 16'h0000;
        m_pend = P_NONE;
        r_pend = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // A response left over from before reset must be dropped.
        force_stray = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        logic [7:0] e_b [3];
        bit         e_16 [4];
        rst_n = 1'b1; i_pop = 1'b0; i_pop_operand = 1'b0; i_pc_load = 1'b0;
        i_pc_target = 16'h0; i_halt = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 8'h00; force_stray = 1'b0; req_cycles = 0;
        gnt_pct = 100; dmin = 0; dmax = 0; stray_pct = 0;
        for (int a = 0; a < 65536; a++)
            mem_img[a] = ($urandom_range(3) == 0) ? 8'hCB : 8'($urandom);
        mem_img[16'h0000] = 8'h00; mem_img[16'h0001] = 8'h3E; mem_img[16'h0002] = 8'h42;
        mem_img[16'h0200] = 8'hCB; mem_img[16'h0201] = 8'h37; mem_img[16'h0202] = 8'h00;
        mem_img[16'h0300] = 8'h3E; mem_img[16'h0301] = 8'h42; mem_img[16'h0302] = 8'hCB;
        mem_img[16'h0303] = 8'h37;
        mem_img[16'h0310] = 8'hCB; mem_img[16'h0311] = 8'h11; mem_img[16'h0312] = 8'h22;
        mem_img[16'h0313] = 8'h33;
        mem_img[16'h0400] = 8'h77; mem_img[16'h0150] = 8'hA5; mem_img[16'hFFFF] = 8'h11;
        @(posedge clk);
        #1;
        do_reset();

        // Boot sequence from address 0 with zero-wait memory.
        clear_logs();
        for (int i = 0; i < 40 && pop_b.size() < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        e_b = '{8'h00, 8'h3E, 8'h42};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("boot_byte%0d", i), (pop_b.size() > i) ? 32'(pop_b[i]) : 32'hDEAD, 32'(e_b[i]));
            chk($sformatf("boot_pc%0d", i), (pop_pc.size() > i) ? 32'(pop_pc[i]) : 32'hDEAD, i);
        end

        // CB prefix marks exactly the following opcode.
        cyc(1'b0, 1'b0, 1'b1, 16'h0200, 1'b0);
        clear_logs();
        for (int i = 0; i < 40 && pop_b.size() < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        e_16 = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++)
            chk($sformatf("cb_is16_%0d", i), (pop_16.size() > i) ? 32'(pop_16[i]) : 32'hDEAD, 32'(e_16[i]));

        // Operand pop between opcodes leaves the prefix flag alone.
        cyc(1'b0, 1'b0, 1'b1, 16'h0300, 1'b0);
        clear_logs();
        for (int i = 0; i < 40 && pop_b.size() < 4; i++)
            cyc(1'b1, pop_b.size() == 1, 1'b0, 16'h0, 1'b0);
        e_16 = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++)
            chk($sformatf("opnd_is16_%0d", i), (pop_16.size() > i) ? 32'(pop_16[i]) : 32'hDEAD, 32'(e_16[i]));

        cyc(1'b0, 1'b0, 1'b1, 16'h0310, 1'b0);
        clear_logs();
        for (int i = 0; i < 40 && pop_b.size() < 4; i++)
            cyc(1'b1, pop_b.size() == 1, 1'b0, 16'h0, 1'b0);
        e_16 = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++)
            chk($sformatf("cbop_is16_%0d", i), (pop_16.size() > i) ? 32'(pop_16[i]) : 32'hDEAD, 32'(e_16[i]));

        // Redirect while a slow read is in flight.
        dmin = 3; dmax = 3;
        cyc(1'b0, 1'b0, 1'b1, 16'h0400, 1'b0);
        gnt_log.delete();
        for (int i = 0; i < 10 && gnt_log.size() == 0; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("redir_gnt_seen", 32'(gnt_log.size() != 0), 32'h1);
        gnt_log.delete();
        cyc(1'b0, 1'b0, 1'b1, 16'h0150, 1'b0);
        for (int i = 0; i < 30 && !o_valid; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("redir_valid", 32'(o_valid), 32'h1);
        chk("redir_pc", 32'(o_pc), 32'h0150);
        chk("redir_byte", 32'(o_byte), 32'hA5);
        chk("redir_addr", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hDEAD, 32'h0150);

        // Fetch address wraps from FFFF to 0000.
        dmin = 0; dmax = 0;
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        clear_logs();
        for (int i = 0; i < 20 && gnt_log.size() < 2; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_addr0", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hDEAD, 32'hFFFF);
        chk("wrap_addr1", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hDEAD, 32'h0000);

        // Halt with a full buffer, then drain it while still halted.
        cyc(1'b0, 1'b0, 1'b1, 16'h0500, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("halt_full_valid", 32'(o_valid), 32'h1);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("halt_req_idle", 32'(req_cycles), 32'h0);
        chk("halt_still_valid", 32'(o_valid), 32'h1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("halt_drained", 32'(o_valid), 32'h0);
        chk("halt_req_drain", 32'(req_cycles), 32'h0);

        // Randomized traffic against the model, with one reset in the middle.
        for (int seg = 0; seg < 12; seg++) begin
            gnt_pct   = int'($urandom_range(100, 30));
            dmin      = 0;
            dmax      = int'($urandom_range(3));
            stray_pct = 10;
            if (seg == 6) do_reset();
            for (int c = 0; c < 250; c++) begin
                rnd_t = 16'($urandom);
                if ($urandom_range(4) == 0) rnd_t = 16'hFFFD;
                cyc($urandom_range(1) == 1, $urandom_range(9) < 3,
                    $urandom_range(99) < 3, rnd_t, $urandom_range(9) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm83_fetch.md
SM83_FETCH -- requirements
Module: sm83_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have ports clk  in  1  sole clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports mem_req out 1 read request; mem_addr out 16 request address; mem_gnt in 1 request accepted.
REQ-004 SHALL have ports mem_rvalid in 1 read data valid; mem_rdata in 8 read byte.
REQ-005 SHALL have ports o_valid out 1 head byte available; o_byte out instr_t head byte; o_pc out 16 address of head byte.
REQ-006 SHALL have port o_is_instr16 out 1: head is the byte after a consumed 0xCB opcode.
REQ-007 SHALL have ports i_pop in 1 consume head; i_pop_operand in 1: popped byte is an immediate operand (1) or an opcode (0).
REQ-008 SHALL have ports i_pc_load in 1 redirect; i_pc_target in 16 new PC; i_halt in 1 suspend new requests.

Function
REQ-009 SHALL keep a byte buffer of DEPTH entries (byte, pc) with count 0..DEPTH, FIFO order.
REQ-010 SHALL drive mem_req=1 only in RUN, with !i_halt, !i_pc_load and count+outstanding < DEPTH; mem_addr=fetch_pc.
REQ-011 SHALL hold mem_req/mem_addr stable until mem_gnt; on req&gnt go to WAIT and increment fetch_pc (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-012 SHALL permit at most one outstanding read; in WAIT, mem_rvalid pushes mem_rdata (tagged with its address) and returns to RUN; mem_rvalid outside WAIT/DISCARD is ignored.
REQ-013 SHALL drive o_valid = (count != 0); o_byte/o_pc show the head combinationally from registers.
REQ-014 SHALL ignore i_pop when o_valid=0; push and pop in the same cycle leave count unchanged.
REQ-015 SHALL set cb_pending when an opcode pop (i_pop_operand=0) carries byte 8'hCB, and clear it on the next opcode pop; o_is_instr16 = cb_pending; operand pops do not change it.
REQ-016 SHALL on i_pc_load: empty the buffer, clear cb_pending, fetch_pc <= i_pc_target; same-cycle i_pop and mem_rvalid are discarded.
REQ-017 SHALL, when i_pc_load arrives in WAIT (rvalid not seen), go to DISCARD; the next mem_rvalid is dropped and state returns to RUN; i_pc_load in DISCARD only updates fetch_pc.
REQ-018 SHALL, with i_halt=1, finish any outstanding read into the buffer and issue no further requests; pops still allowed.
REQ-019 SHALL deliver a byte to o_valid the cycle after mem_rvalid (1-cycle response latency).

Reset
REQ-020 SHALL on rst_n=0 asynchronously set state=RUN, fetch_pc=RESET_PC, count=0, cb_pending=0, mem_req=0, o_valid=0, o_is_instr16=0, o_pc=RESET_PC, o_byte=8'h00.
REQ-021 SHALL drop any in-flight memory response after reset release without pushing it.

Configuration
REQ-022 SHALL use macro SM83_FETCH_PREFETCH_EN: defined -> DEPTH=2, fetch-ahead while buffer has room; undefined -> DEPTH=1, next request issued only after head is popped (count=0).

Structure
REQ-023 SHALL place fetch_state_t (RUN, WAIT, DISCARD), OP_INSTR_16 (8'hCB) and the DEPTH constant in sm83_pkg; instr_t reused from sm83_pkg.
REQ-024 SHALL implement the buffer as sub-module sm83_fetch_buf (depth-parameterised FIFO with flush); the state machine stays in sm83_fetch.

Verification
REQ-025 Reset, mem returns 8'h00,8'h3E,8'h42 at 0x0000..0x0002, zero-wait gnt -> o_byte sequence 00,3E,42 with o_pc 0000,0001,0002.
REQ-026 Bytes CB,37 popped as opcodes -> o_is_instr16=0 for CB, 1 for 37, 0 for following byte.
REQ-027 Opcode 3E popped, operand 42 popped with i_pop_operand=1, then CB -> o_is_instr16 unaffected by operand pop.
REQ-028 i_pc_load target 16'h0150 during WAIT -> stale byte dropped, next mem_addr=0150, o_pc=0150.
REQ-029 fetch_pc=16'hFFFF -> next mem_addr=16'h0000.
REQ-030 i_halt=1 with full buffer and no pops -> mem_req stays 0; with SM83_FETCH_PREFETCH_EN undefined, mem_req stays 0 while o_valid=1.
